// File: rtl/bp_common_pkg.sv
// Shared types and constants for the commit-stream monitor.
// Holds the FSM state encoding and the RISC-V encodings the monitor matches against.
package bp_common_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } bp_commit_mon_state_e;

  // jal x0,0 : the conventional end-of-test spin
  localparam logic [31:0] rv64_self_loop_instr_gp = 32'h0000006f;
  localparam logic [4:0]  rv64_a0_addr_gp         = 5'd10;

endpackage

// File: rtl/bp_commit_mon_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear wins over increment; the count holds at all-ones.
module bp_commit_mon_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i)
      count_o <= '0;
    else if (incr_i && (count_o != '1))
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bp_commit_monitor.sv
// Per-core commit-stream monitor: counts retirements, tracks a0 and ends the test on a
// repeated self-loop, an exception or a watchdog. Define BP_COMMIT_MONITOR_TRACE_EN for trace output.
module bp_commit_monitor
  import bp_common_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int stall_limit_p = 4096,
  parameter int instr_limit_p = 2**20,
  parameter int fail_on_exc_p = 1,
  parameter int cnt_width_p   = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic                     commit_exc_v_i,
  input  logic                     rd_w_v_i,
  input  logic [4:0]               rd_addr_i,
  input  logic [63:0]              rd_data_i,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [cnt_width_p-1:0]   instret_o,
  output logic [63:0]              a0_o
);

  localparam logic [cnt_width_p-1:0] stall_last_lp   = cnt_width_p'(stall_limit_p - 1);
  localparam logic [cnt_width_p-1:0] instr_limit_lp  = cnt_width_p'(instr_limit_p);
  localparam logic                   fail_on_exc_lp  = (fail_on_exc_p != 0);

  bp_commit_mon_state_e state_r, state_n;

  logic [cnt_width_p-1:0]   instret_r, stall_r, instret_inc;
  logic [63:0]              a0_r;
  logic                     prev_loop_r;
  logic [vaddr_width_p-1:0] prev_loop_pc_r;

  logic run, commit, idle, is_loop, loop_end, cap_hit, exc_fail;

  assign run         = (state_r == RUN);
  assign commit      = run & commit_v_i;
  assign idle        = run & ~commit_v_i;
  assign is_loop     = (commit_instr_i == rv64_self_loop_instr_gp);
  assign loop_end    = is_loop & prev_loop_r & (commit_pc_i == prev_loop_pc_r);
  assign instret_inc = (&instret_r) ? instret_r : instret_r + cnt_width_p'(1);
  assign cap_hit     = (instret_inc == instr_limit_lp);
  assign exc_fail    = commit_exc_v_i & fail_on_exc_lp;

  bp_commit_mon_sat_counter #(.width_p(cnt_width_p)) instret_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .incr_i  (commit),
    .count_o (instret_r)
  );

  bp_commit_mon_sat_counter #(.width_p(cnt_width_p)) stall_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (commit),
    .incr_i  (idle),
    .count_o (stall_r)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= RUN;
    else
      state_r <= state_n;
  end

  // Exception beats the self-loop verdict, which beats the instruction cap
  always_comb begin
    state_n = state_r;
    if (commit) begin
      if (exc_fail)
        state_n = FAIL;
      else if (loop_end)
        state_n = (a0_r == 64'd0) ? PASS : FAIL;
      else if (cap_hit)
        state_n = TIMEOUT;
    end else if (idle && (stall_r == stall_last_lp)) begin
      state_n = TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a0_r           <= '0;
      prev_loop_r    <= 1'b0;
      prev_loop_pc_r <= '0;
    end else if (commit) begin
      if (rd_w_v_i && (rd_addr_i == rv64_a0_addr_gp))
        a0_r <= rd_data_i;
      prev_loop_r <= is_loop & ~loop_end;
      if (is_loop)
        prev_loop_pc_r <= commit_pc_i;
    end
  end

  assign done_o    = ~run;
  assign pass_o    = (state_r == PASS);
  assign fail_o    = (state_r == FAIL);
  assign timeout_o = (state_r == TIMEOUT);
  assign instret_o = instret_r;
  assign a0_o      = a0_r;

`ifdef BP_COMMIT_MONITOR_TRACE_EN
  logic [63:0] trace_cycle_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      trace_cycle_r <= '0;
    else
      trace_cycle_r <= trace_cycle_r + 64'd1;
    if (!reset_i && commit)
      $display("[commit] cycle=%0d pc=%h instr=%h rd_w=%0b rd=x%0d data=%h",
               trace_cycle_r, commit_pc_i, commit_instr_i, rd_w_v_i, rd_addr_i, rd_data_i);
    if (!reset_i && run && (state_n != RUN))
      $display("[commit] verdict=%s instret=%0d", state_n.name(),
               commit ? instret_inc : instret_r);
  end
`endif

endmodule
